// File: rtl/isr_bank.sv
// In-service register bank: tracks serviced IRQ levels, resolves the highest in-service level,
// owns rotating priority, EOI handling (specific/non-specific/automatic) and special mask mode.
module isr_bank #(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               latch_in_service,
    input  logic [NUM_IRQ-1:0] interrupt,
    input  logic               inta_end,
    input  logic               auto_eoi_mode,
    input  logic               eoi_nonspecific,
    input  logic               eoi_specific,
    input  logic [IDX_W-1:0]   eoi_level,
    input  logic               set_priority,
    input  logic               rotate_on_eoi,
    input  logic               special_mask_mode,
    input  logic [NUM_IRQ-1:0] interrupt_mask,
    output logic [NUM_IRQ-1:0] in_service_register,
    output logic [NUM_IRQ-1:0] highest_level_in_service,
    output logic [IDX_W-1:0]   priority_rotate,
    output logic               eoi_error,
    output logic               protocol_error
);

    typedef enum logic {IDLE, ACK} state_t;

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   pend_lvl, pend_nxt;
    logic [IDX_W-1:0]   rot_nxt;
    logic [IDX_W-1:0]   hi_idx;
    logic [IDX_W-1:0]   int_idx;
    logic [NUM_IRQ-1:0] eff_isr;
    logic [NUM_IRQ-1:0] set_vec, clr_ns, clr_sp, clr_ae;
    logic               int_valid, lvl_ok, aeoi_clear;

    // Ring position 'off' steps above base, wrapping modulo NUM_IRQ (need not be a power of 2).
    function automatic logic [IDX_W-1:0] ring_idx(input logic [IDX_W-1:0] base, input int unsigned off);
        int unsigned t;
        t = 32'(base) + off;
        if (t >= NUM_IRQ) t = t - NUM_IRQ;
        return IDX_W'(t);
    endfunction

    function automatic logic [NUM_IRQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_IRQ-1:0] v;
        for (int i = 0; i < NUM_IRQ; i++) v[i] = (idx == IDX_W'(i));
        return v;
    endfunction

    // Priority resolution: walk from lowest to highest priority so the highest-priority hit wins.
    always_comb begin
        eff_isr                  = in_service_register & ~(special_mask_mode ? interrupt_mask : '0);
        highest_level_in_service = '0;
        hi_idx                   = '0;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (eff_isr[ring_idx(priority_rotate, k + 1)]) begin
                highest_level_in_service = to_onehot(ring_idx(priority_rotate, k + 1));
                hi_idx                   = ring_idx(priority_rotate, k + 1);
            end
        end
    end

    always_comb begin
        int_idx = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (interrupt[i]) int_idx = IDX_W'(i);
        end
        int_valid = ($countones(interrupt) == 1);
    end

    always_comb begin
        lvl_ok     = ({1'b0, eoi_level} < (IDX_W + 1)'(NUM_IRQ));
        set_vec    = latch_in_service ? interrupt : '0;
        clr_ns     = eoi_nonspecific ? highest_level_in_service : '0;
        clr_sp     = (eoi_specific && lvl_ok) ? to_onehot(eoi_level) : '0;
        aeoi_clear = (state == ACK) && (inta_end || latch_in_service);
        clr_ae     = aeoi_clear ? to_onehot(pend_lvl) : '0;

        rot_nxt = priority_rotate;
        if (set_priority && lvl_ok)
            rot_nxt = eoi_level;
        else if (rotate_on_eoi) begin
            if (eoi_specific && lvl_ok)
                rot_nxt = eoi_level;
            else if (eoi_nonspecific && (highest_level_in_service != '0))
                rot_nxt = hi_idx;
            else if (aeoi_clear)
                rot_nxt = pend_lvl;
        end
    end

    // AEOI tracker: a latch while already in ACK retires the old level and may arm a new one.
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend_lvl;
        case (state)
            IDLE: begin
                if (latch_in_service && auto_eoi_mode && int_valid) begin
                    state_nxt = ACK;
                    pend_nxt  = int_idx;
                end
            end
            ACK: begin
                if (latch_in_service) begin
                    if (auto_eoi_mode && int_valid) begin
                        state_nxt = ACK;
                        pend_nxt  = int_idx;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else if (inta_end) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state               <= IDLE;
            pend_lvl            <= '0;
            in_service_register <= '0;
            priority_rotate     <= IDX_W'(NUM_IRQ - 1);
            eoi_error           <= 1'b0;
            protocol_error      <= 1'b0;
        end else begin
            state               <= state_nxt;
            pend_lvl            <= pend_nxt;
            in_service_register <= (in_service_register & ~(clr_ns | clr_sp | clr_ae)) | set_vec;
            priority_rotate     <= rot_nxt;
            eoi_error           <= eoi_nonspecific && (highest_level_in_service == '0);
            protocol_error      <= latch_in_service && !int_valid;
        end
    end

endmodule

// File: tb/tb_isr_bank.sv
// Directed bench for isr_bank (NUM_IRQ=8): hand-computed ISR, priority and error-pulse expectations.
module tb_isr_bank;

    logic       clk = 1'b0;
    logic       reset;
    logic       latch_in_service;
    logic [7:0] interrupt;
    logic       inta_end;
    logic       auto_eoi_mode;
    logic       eoi_nonspecific;
    logic       eoi_specific;
    logic [2:0] eoi_level;
    logic       set_priority;
    logic       rotate_on_eoi;
    logic       special_mask_mode;
    logic [7:0] interrupt_mask;
    logic [7:0] in_service_register;
    logic [7:0] highest_level_in_service;
    logic [2:0] priority_rotate;
    logic       eoi_error;
    logic       protocol_error;

    int n_cmp = 0;
    int n_bad = 0;

    isr_bank #(.NUM_IRQ(8)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .latch_in_service         (latch_in_service),
        .interrupt                (interrupt),
        .inta_end                 (inta_end),
        .auto_eoi_mode            (auto_eoi_mode),
        .eoi_nonspecific          (eoi_nonspecific),
        .eoi_specific             (eoi_specific),
        .eoi_level                (eoi_level),
        .set_priority             (set_priority),
        .rotate_on_eoi            (rotate_on_eoi),
        .special_mask_mode        (special_mask_mode),
        .interrupt_mask           (interrupt_mask),
        .in_service_register      (in_service_register),
        .highest_level_in_service (highest_level_in_service),
        .priority_rotate          (priority_rotate),
        .eoi_error                (eoi_error),
        .protocol_error           (protocol_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses: drive for one cycle then drop.
    task automatic latch(input logic [7:0] v);
        latch_in_service = 1'b1; interrupt = v;
        tick();
        latch_in_service = 1'b0; interrupt = '0;
    endtask

    task automatic eoi_spec(input logic [2:0] lvl);
        eoi_specific = 1'b1; eoi_level = lvl;
        tick();
        eoi_specific = 1'b0; eoi_level = '0;
    endtask

    task automatic eoi_ns();
        eoi_nonspecific = 1'b1;
        tick();
        eoi_nonspecific = 1'b0;
    endtask

    task automatic end_ack();
        inta_end = 1'b1;
        tick();
        inta_end = 1'b0;
    endtask

    initial begin
        reset = 1'b1; latch_in_service = 1'b0; interrupt = '0; inta_end = 1'b0;
        auto_eoi_mode = 1'b0; eoi_nonspecific = 1'b0; eoi_specific = 1'b0; eoi_level = '0;
        set_priority = 1'b0; rotate_on_eoi = 1'b0; special_mask_mode = 1'b0; interrupt_mask = '0;
        tick(); tick();
        reset = 1'b0;
        check("rst_isr", in_service_register, 8'h00);
        check("rst_rot", priority_rotate, 3'd7);
        check("rst_high", highest_level_in_service, 8'h00);
        check("rst_errs", {eoi_error, protocol_error}, 2'b00);

        // Plain latch
        latch(8'h08);
        check("t1_isr", in_service_register, 8'h08);
        check("t1_high", highest_level_in_service, 8'h08);
        check("t1_rot", priority_rotate, 3'd7);
        check("t1_perr", protocol_error, 1'b0);
        eoi_spec(3'd3);
        check("t1_clr", in_service_register, 8'h00);

        // Multi-hot latch sets both bits and flags a protocol error; then rotating non-specific EOI
        latch(8'h24);
        check("t2_isr", in_service_register, 8'h24);
        check("t2_perr", protocol_error, 1'b1);
        check("t2_high", highest_level_in_service, 8'h04);
        rotate_on_eoi = 1'b1;
        eoi_ns();
        rotate_on_eoi = 1'b0;
        check("t2_isr_eoi", in_service_register, 8'h20);
        check("t2_rot", priority_rotate, 3'd2);
        check("t2_high_eoi", highest_level_in_service, 8'h20);
        check("t2_perr_gone", protocol_error, 1'b0);

        // Set priority, then special mask mode hides the top level
        set_priority = 1'b1; eoi_level = 3'd4;
        tick();
        set_priority = 1'b0; eoi_level = '0;
        check("t3_rot", priority_rotate, 3'd4);
        latch(8'h01);
        check("t3_isr", in_service_register, 8'h21);
        check("t3_high", highest_level_in_service, 8'h20);
        special_mask_mode = 1'b1; interrupt_mask = 8'h20;
        #1;
        check("t3_high_smm", highest_level_in_service, 8'h01);
        interrupt_mask = 8'h21;
        #1;
        check("t3_high_allmask", highest_level_in_service, 8'h00);
        special_mask_mode = 1'b0; interrupt_mask = '0;
        eoi_spec(3'd5);
        eoi_spec(3'd0);
        check("t3_clr", in_service_register, 8'h00);
        check("t3_rot_kept", priority_rotate, 3'd4);

        // Non-specific EOI with nothing in service
        eoi_ns();
        check("t5_eoierr", eoi_error, 1'b1);
        check("t5_isr", in_service_register, 8'h00);
        check("t5_rot", priority_rotate, 3'd4);
        tick();
        check("t5_eoierr_gone", eoi_error, 1'b0);
        latch(8'h11);
        check("t5_isr2", in_service_register, 8'h11);
        check("t5_perr", protocol_error, 1'b1);
        eoi_spec(3'd0);
        eoi_spec(3'd4);
        check("t5_clr", in_service_register, 8'h00);
        latch(8'h00);
        check("t5_zero_perr", protocol_error, 1'b1);
        check("t5_zero_isr", in_service_register, 8'h00);

        // AEOI with rotation: bit1 held for two cycles, cleared on inta_end
        auto_eoi_mode = 1'b1; rotate_on_eoi = 1'b1;
        latch(8'h02);
        check("t4_isr_c1", in_service_register, 8'h02);
        tick();
        check("t4_isr_c2", in_service_register, 8'h02);
        end_ack();
        check("t4_isr_clr", in_service_register, 8'h00);
        check("t4_rot", priority_rotate, 3'd1);
        // Back in IDLE: a non-AEOI latch must survive a stray inta_end
        auto_eoi_mode = 1'b0; rotate_on_eoi = 1'b0;
        latch(8'h02);
        end_ack();
        check("t4_idle", in_service_register, 8'h02);
        eoi_spec(3'd1);

        // ACK + new latch: old AEOI level retired, new one armed
        latch(8'h08);
        auto_eoi_mode = 1'b1;
        latch(8'h01);
        check("t7_isr_a", in_service_register, 8'h09);
        latch(8'h02);
        check("t7_isr_b", in_service_register, 8'h0A);
        end_ack();
        check("t7_isr_c", in_service_register, 8'h08);
        check("t7_rot", priority_rotate, 3'd1);
        auto_eoi_mode = 1'b0;
        eoi_spec(3'd3);

        // Simultaneous set and specific clear of the same bit keeps it set
        latch_in_service = 1'b1; interrupt = 8'h04; eoi_specific = 1'b1; eoi_level = 3'd2;
        tick();
        latch_in_service = 1'b0; interrupt = '0; eoi_specific = 1'b0; eoi_level = '0;
        check("t6_setwins", in_service_register, 8'h04);

        // Reset mid-acknowledge discards the pending AEOI
        auto_eoi_mode = 1'b1;
        latch(8'h08);
        check("t6_isr_pre", in_service_register, 8'h0C);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_rst_isr", in_service_register, 8'h00);
        check("t6_rst_rot", priority_rotate, 3'd7);
        auto_eoi_mode = 1'b0;
        latch(8'h08);
        end_ack();
        check("t6_rst_idle", in_service_register, 8'h08);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
